// File: rtl/alu_md_if.sv
// rtl/alu_md_if.sv - operand, ALU result and mult/div handshake bundle for alu_md
interface alu_md_if #(parameter int WIDTH = 32);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             signed_comp;
   logic [WIDTH-1:0] s;
   logic             overflow;
   logic             eq;
   logic             ne;
   logic             lt;
   logic             le;
   logic             gt;
   logic             ge;
   logic             md_start;
   logic [2:0]       md_op;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output a, b, op, signed_comp, md_start, md_op,
      input  s, overflow, eq, ne, lt, le, gt, ge, busy, hi, lo
   );

   modport slave (
      input  a, b, op, signed_comp, md_start, md_op,
      output s, overflow, eq, ne, lt, le, gt, ge, busy, hi, lo
   );
endinterface

// File: rtl/alu_md.sv
// rtl/alu_md.sv - EX-stage combinational ALU plus iterative multiply/divide with HI/LO
module alu_md #(
   parameter int WIDTH = 32
) (
   input logic    clk,
   input logic    reset,
   alu_md_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   // ---------------- ALU ----------------
   logic [WIDTH-1:0] add_r;
   logic [WIDTH-1:0] sub_r;
   logic [SW-1:0]    shamt;
   logic             lt_s;
   logic             lt_u;
   logic [WIDTH-1:0] alu_s;
   logic             alu_ovf;

   assign add_r = bus.a + bus.b;
   assign sub_r = bus.a - bus.b;
   assign shamt = bus.b[SW-1:0];
   assign lt_s  = $signed(bus.a) < $signed(bus.b);
   assign lt_u  = bus.a < bus.b;

   // ALU result and ADD/SUB signed overflow
   always_comb begin
      alu_s   = '0;
      alu_ovf = 1'b0;
      case (bus.op)
         4'd0: begin
            alu_s   = add_r;
            alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_r[WIDTH-1] != bus.a[WIDTH-1]);
         end
         4'd1: begin
            alu_s   = sub_r;
            alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_r[WIDTH-1] != bus.a[WIDTH-1]);
         end
         4'd2:    alu_s = bus.a & bus.b;
         4'd3:    alu_s = bus.a | bus.b;
         4'd4:    alu_s = bus.a ^ bus.b;
         4'd5:    alu_s = ~(bus.a | bus.b);
         4'd6:    alu_s = bus.a << shamt;
         4'd7:    alu_s = bus.a >> shamt;
         4'd8:    alu_s = $signed(bus.a) >>> shamt;
         4'd9:    alu_s = {{(WIDTH-1){1'b0}}, lt_s};
         4'd10:   alu_s = {{(WIDTH-1){1'b0}}, lt_u};
         4'd11:   alu_s = bus.b << (WIDTH / 2);
         default: alu_s = '0;
      endcase
   end

   assign bus.s        = alu_s;
   assign bus.overflow = alu_ovf;
   assign bus.eq       = (bus.a == bus.b);
   assign bus.ne       = (bus.a != bus.b);
   assign bus.lt       = bus.signed_comp ? lt_s : lt_u;
   assign bus.le       = bus.lt | bus.eq;
   assign bus.gt       = ~bus.le;
   assign bus.ge       = ~bus.lt;

   // ---------------- multiply/divide engine ----------------
   // acc holds {partial product} for multiply, {remainder, quotient} for divide
   state_t             state;
   logic               busy_q;
   logic [CW-1:0]      cnt;
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic               b_zero;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   a_raw;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] hilo_q;

   logic               signed_op;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   mag_a_in;
   logic [WIDTH-1:0]   mag_b_in;

   assign signed_op = (bus.md_op == 3'd0) || (bus.md_op == 3'd2);
   assign a_neg     = signed_op & bus.a[WIDTH-1];
   assign b_neg     = signed_op & bus.b[WIDTH-1];
   assign mag_a_in  = a_neg ? -bus.a : bus.a;
   assign mag_b_in  = b_neg ? -bus.b : bus.b;

   logic [WIDTH:0]     add_step;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] prod_f;
   logic [WIDTH-1:0]   quo_f;
   logic [WIDTH-1:0]   rem_f;

   // one shift-add or one restoring-divide step, plus sign fix-up of the final step
   always_comb begin
      add_step = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
      shifted  = acc[2*WIDTH-1:WIDTH-1];
      diff     = shifted - {1'b0, mag_b};
      if (is_div) begin
         acc_next = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = {add_step, acc[WIDTH-1:1]};
      end
      prod_f = neg_res ? -acc_next : acc_next;
      quo_f  = neg_res ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
      rem_f  = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
   end

   // engine FSM: latch operands on start, iterate WIDTH times, write HI/LO on the last step
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         busy_q  <= 1'b0;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         b_zero  <= 1'b0;
         mag_b   <= '0;
         a_raw   <= '0;
         acc     <= '0;
         hilo_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.md_start) begin
                  case (bus.md_op)
                     3'd0, 3'd1, 3'd2, 3'd3: begin
                        state   <= RUN;
                        busy_q  <= 1'b1;
                        cnt     <= '0;
                        is_div  <= bus.md_op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        b_zero  <= (bus.b == '0);
                        mag_b   <= mag_b_in;
                        a_raw   <= bus.a;
                        acc     <= {{WIDTH{1'b0}}, mag_a_in};
                     end
                     3'd4:    hilo_q[2*WIDTH-1:WIDTH] <= bus.a;
                     3'd5:    hilo_q[WIDTH-1:0]       <= bus.a;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  if (!is_div)    hilo_q <= prod_f;
                  else if (b_zero) hilo_q <= {a_raw, {WIDTH{1'b1}}};
                  else            hilo_q <= {rem_f, quo_f};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.hi   = hilo_q[2*WIDTH-1:WIDTH];
   assign bus.lo   = hilo_q[WIDTH-1:0];
endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - directed checks of alu_md at WIDTH 32 plus model sweep at 8 and 16
module tb_alu_md;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   int   cyc;

   alu_md_if #(.WIDTH(32)) bus32 ();
   alu_md_if #(.WIDTH(8))  bus8 ();
   alu_md_if #(.WIDTH(16)) bus16 ();

   alu_md #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
   alu_md #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
   alu_md #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // independent reference for the sweep: {hi[15:0], lo[15:0]}
   function automatic logic [31:0] md_model(input int w, input logic [2:0] op,
                                            input logic [15:0] a, input logic [15:0] b);
      longint m, ua, ub, sa, sb, p, hi, lo;
      m  = (longint'(1) << w) - 1;
      ua = longint'(a) & m;
      ub = longint'(b) & m;
      sa = ((ua >> (w - 1)) != 0) ? ua - (m + 1) : ua;
      sb = ((ub >> (w - 1)) != 0) ? ub - (m + 1) : ub;
      hi = 0;
      lo = 0;
      case (op)
         3'd0: begin p = sa * sb; lo = p & m; hi = (p >>> w) & m; end
         3'd1: begin p = ua * ub; lo = p & m; hi = (p >> w) & m; end
         3'd2: if (ub == 0) begin lo = m; hi = ua; end
               else begin lo = (sa / sb) & m; hi = (sa % sb) & m; end
         3'd3: if (ub == 0) begin lo = m; hi = ua; end
               else begin lo = (ua / ub) & m; hi = (ua % ub) & m; end
         default: ;
      endcase
      return {hi[15:0], lo[15:0]};
   endfunction

   task automatic alu32(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic sc, input logic [31:0] exp_s,
                        input logic exp_ovf);
      @(negedge clk);
      bus32.op = op; bus32.a = a; bus32.b = b; bus32.signed_comp = sc;
      #1;
      check(tag, {bus32.overflow, bus32.s}, {exp_ovf, exp_s});
   endtask

   // starts an op, optionally pulses MTHI(0x1234) at busy cycle inj, counts busy cycles
   task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output int cycles);
      logic [31:0] hi0;
      @(negedge clk);
      hi0 = bus32.hi;
      bus32.md_op = op; bus32.a = a; bus32.b = b; bus32.md_start = 1'b1;
      @(negedge clk);
      bus32.md_start = 1'b0;
      cycles = 0;
      while (bus32.busy && cycles < 200) begin
         if (cycles == inj) begin
            bus32.md_op = 3'd4; bus32.a = 32'h1234; bus32.md_start = 1'b1;
         end else begin
            bus32.md_start = 1'b0;
         end
         if (cycles == 16) check("hold_hi", {32'h0, bus32.hi}, {32'h0, hi0});
         @(negedge clk);
         cycles++;
      end
      bus32.md_start = 1'b0;
   endtask

   task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int c;
      @(negedge clk);
      bus8.md_op = op; bus8.a = a; bus8.b = b; bus8.md_start = 1'b1;
      @(negedge clk);
      bus8.md_start = 1'b0;
      c = 0;
      while (bus8.busy && c < 100) begin @(negedge clk); c++; end
      check($sformatf("sw8_op%0d_%h_%h", op, a, b), {32'(c), 8'h0, bus8.hi, 8'h0, bus8.lo},
            {32'd8, md_model(8, op, {8'h0, a}, {8'h0, b})});
   endtask

   task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      int c;
      @(negedge clk);
      bus16.md_op = op; bus16.a = a; bus16.b = b; bus16.md_start = 1'b1;
      @(negedge clk);
      bus16.md_start = 1'b0;
      c = 0;
      while (bus16.busy && c < 100) begin @(negedge clk); c++; end
      check($sformatf("sw16_op%0d_%h_%h", op, a, b), {32'(c), bus16.hi, bus16.lo},
            {32'd16, md_model(16, op, a, b)});
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      bus32.a = '0; bus32.b = '0; bus32.op = '0; bus32.signed_comp = 1'b0;
      bus32.md_start = 1'b0; bus32.md_op = '0;
      bus8.a = '0; bus8.b = '0; bus8.op = '0; bus8.signed_comp = 1'b0;
      bus8.md_start = 1'b0; bus8.md_op = '0;
      bus16.a = '0; bus16.b = '0; bus16.op = '0; bus16.signed_comp = 1'b0;
      bus16.md_start = 1'b0; bus16.md_op = '0;
      repeat (2) @(negedge clk);
      check("reset_state", {31'h0, bus32.busy, bus32.hi}, {63'h0, 1'b0});
      check("reset_lo", {32'h0, bus32.lo}, 64'h0);
      reset = 1'b0;

      alu32("add_ovf",  4'd0,  32'h7FFFFFFF, 32'h1,        1'b1, 32'h80000000, 1'b1);
      alu32("sub",      4'd1,  32'd5,        32'd7,        1'b1, 32'hFFFFFFFE, 1'b0);
      alu32("sub_ovf",  4'd1,  32'h80000000, 32'h1,        1'b1, 32'h7FFFFFFF, 1'b1);
      alu32("and_novf", 4'd2,  32'h7FFFFFFF, 32'h1,        1'b1, 32'h00000001, 1'b0);
      alu32("nor",      4'd5,  32'h0,        32'h0,        1'b1, 32'hFFFFFFFF, 1'b0);
      alu32("sll",      4'd6,  32'h1,        32'h25,       1'b1, 32'h00000020, 1'b0);
      alu32("srl",      4'd7,  32'h80000000, 32'h4,        1'b1, 32'h08000000, 1'b0);
      alu32("sra",      4'd8,  32'h80000000, 32'h4,        1'b1, 32'hF8000000, 1'b0);
      alu32("sltu",     4'd10, 32'h1,        32'hFFFFFFFF, 1'b1, 32'h1,        1'b0);
      alu32("slt",      4'd9,  32'h1,        32'hFFFFFFFF, 1'b1, 32'h0,        1'b0);
      check("flags_signed", {58'h0, bus32.eq, bus32.ne, bus32.lt, bus32.le, bus32.gt, bus32.ge},
            {58'h0, 6'b010011});
      alu32("lui",      4'd11, 32'h0,        32'h1234,     1'b0, 32'h12340000, 1'b0);
      check("flags_unsigned", {58'h0, bus32.eq, bus32.ne, bus32.lt, bus32.le, bus32.gt, bus32.ge},
            {58'h0, 6'b011100});
      alu32("op15",     4'd15, 32'hFFFF,     32'h1,        1'b0, 32'h0,        1'b0);

      run32(3'd0, 32'hFFFFFFFD, 32'd7, -1, cyc);
      check("mult_cycles", 64'(cyc), 64'd32);
      check("mult", {bus32.hi, bus32.lo}, 64'hFFFFFFFF_FFFFFFEB);
      run32(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, cyc);
      check("multu", {bus32.hi, bus32.lo}, 64'hFFFFFFFE_00000001);
      run32(3'd0, 32'd5, 32'd6, 5, cyc);
      check("mult_collide", {bus32.hi, bus32.lo}, 64'h00000000_0000001E);
      run32(3'd2, 32'hFFFFFFF9, 32'd2, -1, cyc);
      check("div", {bus32.hi, bus32.lo}, 64'hFFFFFFFF_FFFFFFFD);
      run32(3'd3, 32'd7, 32'd0, -1, cyc);
      check("divu_zero", {bus32.hi, bus32.lo}, 64'h00000007_FFFFFFFF);
      run32(3'd2, 32'hFFFFFFF9, 32'd0, -1, cyc);
      check("div_zero_neg", {bus32.hi, bus32.lo}, 64'hFFFFFFF9_FFFFFFFF);
      run32(3'd2, 32'h80000000, 32'hFFFFFFFF, -1, cyc);
      check("div_min_m1", {bus32.hi, bus32.lo}, 64'h00000000_80000000);

      @(negedge clk);
      bus32.md_op = 3'd5; bus32.a = 32'hABCD; bus32.md_start = 1'b1;
      @(negedge clk);
      bus32.md_start = 1'b0;
      check("mtlo", {31'h0, bus32.busy, bus32.lo}, {31'h0, 1'b0, 32'hABCD});
      bus32.md_op = 3'd4; bus32.a = 32'h5A5A; bus32.md_start = 1'b1;
      @(negedge clk);
      bus32.md_op = 3'd6; bus32.a = 32'h1111; bus32.md_start = 1'b1;
      check("mthi", {bus32.hi, bus32.lo}, 64'h00005A5A_0000ABCD);
      @(negedge clk);
      bus32.md_start = 1'b0;
      check("nop_op6", {31'h0, bus32.busy, bus32.hi, bus32.lo}, {31'h0, 1'b0, 64'h00005A5A_0000ABCD});

      @(negedge clk);
      bus32.md_op = 3'd2; bus32.a = 32'd100; bus32.b = 32'd3; bus32.md_start = 1'b1;
      @(negedge clk);
      bus32.md_start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_abort", {31'h0, bus32.busy, bus32.hi, bus32.lo}, 96'h0);
      @(negedge clk);
      reset = 1'b0;
      run32(3'd1, 32'd3, 32'd4, -1, cyc);
      check("multu_after_reset", {32'(cyc), bus32.hi, bus32.lo}, {32'd32, 64'h0000000C});

      run8(3'd2, 8'h80, 8'hFF);
      run16(3'd2, 16'h8000, 16'hFFFF);
      for (int i = 0; i < 12; i++) begin
         ra = 16'($urandom);
         rb = (i % 3 == 2) ? 16'h0 : 16'($urandom);
         run8(3'(i % 4), ra[7:0], rb[7:0]);
         run16(3'(i % 4), ra, rb);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/alu_md.md
# alu_md

Parametrised execute-stage unit: a single-cycle combinational ALU (arithmetic, logic, shift and compare) plus an iterative multiply/divide engine with architectural HI/LO registers. It sits in the EX stage of the pipelined CPU. The ALU result and flags are combinational. Multiply/divide runs one bit per cycle behind a start/busy handshake, and the stall logic uses `busy` to hold dependent instructions.

## Interface
- WIDTH, 32, datapath width; must be ≥ 4 and even.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears HI, LO, busy and the engine state.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt/imm); shift amount is b[log2(WIDTH)-1:0].
- op  input  4  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 LUI (b << WIDTH/2); 12–15 give s = 0.
- signed_comp  input  1  selects signed (1) or unsigned (0) compare for the flag outputs.
- s  output  WIDTH  ALU result, combinational.
- overflow  output  1  signed overflow of ADD/SUB; 0 for all other ops.
- eq, ne, lt, le, gt, ge  output  1 each  comparison of a against b, combinational.
- md_start  input  1  one-cycle request, qualified by md_op.
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-op.
- busy  output  1  engine running.
- hi, lo  output  WIDTH  HI/LO registers.

## Operation
- ALU path is purely combinational and independent of the engine state.
- SLT/SLTU return zero-extended 1 or 0. SRA replicates a[WIDTH-1].
- Overflow rules: ADD sets overflow when the operand signs are equal and the result sign differs. SUB sets it when the operand signs differ and the result sign differs from a.
- Engine states:
  - IDLE → RUN on md_start with md_op 0–3 while not busy. On entry, a and b are latched (as magnitudes for signed ops), the iteration counter is cleared, and the result sign and remainder sign are recorded.
  - RUN → IDLE after WIDTH iterations. HI/LO are written on the same edge.
- Iterations:
  - MULT/MULTU use shift-add, one bit per iteration. Final result: {HI, LO} = 2·WIDTH-bit product; a signed product is negated when the operand signs differ.
  - DIV/DIVU use restoring division, one quotient bit per iteration. LO = quotient, truncated toward zero. HI = remainder, which takes the sign of the dividend.
- Divide by zero (b = 0): the engine still runs WIDTH cycles, then writes LO = all-ones and HI = a (the raw latched dividend).
- Signed minimum ÷ −1: LO = minimum value, HI = 0. No trap.
- MTHI/MTLO: when not busy, HI (resp. LO) ← a at the next edge. busy stays 0.
- Ignored requests: md_start while busy, of any md_op. The in-flight operation is unaffected.
- md_op 6–7 with md_start: no effect.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, engine state IDLE. Reset asserted mid-operation aborts immediately and leaves HI/LO = 0.
- Request sampled at edge E0 → busy = 1 from after E0 through edge E0+WIDTH. HI/LO are updated at E0+WIDTH, and busy = 0 in the same cycle the new values appear. Latency is WIDTH cycles; back-to-back start is allowed at edge E0+WIDTH, the cycle busy drops.
- HI/LO keep their old values while busy = 1.
- MTHI/MTLO latency: 1 edge.
- busy is a registered output. s, overflow and the flags are combinational from a, b, op and signed_comp.

## Test plan
- ALU ops, WIDTH=32:
  - ADD 0x7FFFFFFF + 1 → s = 0x80000000, overflow = 1.
  - SUB 5 − 7 → 0xFFFFFFFE, overflow = 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLTU 1, 0xFFFFFFFF → 1.
  - SLT with the same operands → 0.
- MULT −3 × 7, start at cycle 0 → busy high for exactly 32 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 7 / 0 → lo = 0xFFFFFFFF, hi = 7. DIV 0x80000000 / −1 → lo = 0x80000000, hi = 0.
- Collisions:
  - md_start MTHI(a = 0x1234) on cycle 5 of a MULT → ignored; final HI is the product.
  - MTLO(a = 0xABCD) when idle → lo = 0xABCD after 1 edge, busy stays 0.
- Reset asserted on cycle 10 of a DIV → busy, hi and lo = 0 immediately. A new MULTU 3×4 then completes after 32 cycles with hi = 0, lo = 12.
- Parameter sweep WIDTH=8 and WIDTH=16 against a reference model over random MULT/DIV (signed and unsigned), including b = 0; busy duration equals WIDTH.
